gate_eval_pipe: RTL and testbench
=================================

GATE_EVAL_PIPE -- requirements
Module: gate_eval_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit width of every data lane (legal range 1..64).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the transfer counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port A  input  WIDTH  operand A.
REQ-006 SHALL have port B  input  WIDTH  operand B.
REQ-007 SHALL have port C  input  WIDTH  operand C.
REQ-008 SHALL have port MODE  input  2  function select, sampled with the operands.
REQ-009 SHALL have port in_valid  input  1  operands and MODE are valid.
REQ-010 SHALL have port in_ready  output  1  block accepts the operands this cycle.
REQ-011 SHALL have port D  output  WIDTH  registered function result.
REQ-012 SHALL have port E  output  WIDTH  registered complement of C.
REQ-013 SHALL have port out_valid  output  1  D and E are valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts D and E.
REQ-015 SHALL have port xfer_cnt  output  CNT_W  count of completed output transfers.

Function
REQ-016 An input transfer SHALL occur when in_valid and in_ready are both high at a clock edge; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-017 The function SHALL be bitwise per lane: MODE 0 SOP gives D=(A&B)|~C; MODE 1 POS gives D=(A|B)&~C; MODE 2 XOR gives D=(A^B)|~C; MODE 3 is reserved and SHALL behave as MODE 0.
REQ-018 E SHALL equal ~C in every mode.
REQ-019 The block SHALL be a two-stage pipeline: stage 1 registers A, B, C and MODE; stage 2 registers D and E, computed from the stage-1 contents.
REQ-020 Each stage SHALL hold a valid flag; a stage SHALL load when it is empty or its contents leave this cycle.
REQ-021 in_ready SHALL equal (!s1_valid) | (stage 1 advances this cycle); stage 1 advances when s1_valid & ((!out_valid) | out_ready).
REQ-022 With out_ready held high, latency from the input transfer to out_valid SHALL be exactly 2 cycles, and throughput SHALL be 1 transfer per cycle.
REQ-023 While out_valid is high and out_ready is low, D, E and out_valid SHALL hold stable, and no data SHALL be lost or duplicated.
REQ-024 Input transfer, stage advance and output transfer in the same cycle SHALL all complete, with no bubble inserted.
REQ-025 xfer_cnt SHALL increment by 1 on each output transfer and SHALL wrap from 2^CNT_W-1 to 0.
REQ-026 in_ready SHALL be combinational from out_ready; no other output SHALL depend combinationally on any input.

Reset
REQ-027 When rst is high at a clock edge, s1_valid, out_valid and xfer_cnt SHALL become 0, and D and E SHALL become all-zero.
REQ-028 Reset mid-operation SHALL discard all in-flight data; no transfer SHALL be reported for data held in either stage.
REQ-029 in_ready SHALL be high in the first cycle after rst deasserts.

Structure
REQ-030 Package gate_eval_pkg SHALL hold the MODE encodings (MODE_SOP=0, MODE_POS=1, MODE_XOR=2, MODE_RSVD=3) and the default WIDTH and CNT_W constants.
REQ-031 Combinational function evaluation SHALL live in sub-module gate_eval_core (inputs A, B, C and MODE; outputs D and E; parameter WIDTH), instantiated once between the two stages.

Verification
REQ-032 Pipeline test: WIDTH=4, MODE=0, A=1100, B=1010, C=0110, out_ready=1 -> after 2 cycles out_valid=1, D=1001, E=1001.
REQ-033 Mode test: same operands with MODE=1 -> D=1000; MODE=2 -> D=1111; MODE=3 -> D=1001; E=1001 in all three cases.
REQ-034 Backpressure test: stream 5 distinct vectors with out_ready low for cycles 3-6 -> D and E stay stable while stalled, in_ready drops once both stages are full, and all 5 results emerge in order with none lost or duplicated.
REQ-035 Throughput test: 100 back-to-back vectors with out_ready=1 -> 100 consecutive out_valid cycles and xfer_cnt=100.
REQ-036 Wrap test: CNT_W=4, 17 transfers -> xfer_cnt reads 15, then 0, then 1.
REQ-037 Reset test: assert rst with both stages full -> next cycle out_valid=0, D=0, E=0, xfer_cnt=0 and in_ready=1.

Source files
------------

// File: rtl/gate_eval_pkg.sv
// Shared constants for the gate evaluation pipeline: function-select encodings and default widths.
package gate_eval_pkg;

    localparam logic [1:0] MODE_SOP  = 2'd0;
    localparam logic [1:0] MODE_POS  = 2'd1;
    localparam logic [1:0] MODE_XOR  = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_CNT_W = 16;

endpackage

// File: rtl/gate_eval_core.sv
// Purely combinational per-lane gate function; E is always the complement of C.
module gate_eval_core
    import gate_eval_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       MODE,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E
);

    always_comb begin
        E = ~C;
        D = (A & B) | ~C;
        // The reserved encoding deliberately falls through to SOP.
        case (MODE)
            MODE_POS: D = (A | B) & ~C;
            MODE_XOR: D = (A ^ B) | ~C;
            default:  D = (A & B) | ~C;
        endcase
    end

endmodule

// File: rtl/gate_eval_pipe.sv
// Two-stage valid/ready pipeline: stage 1 holds operands, stage 2 holds the evaluated result.
module gate_eval_pipe
    import gate_eval_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [1:0]       MODE,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] E,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             s1_valid_q;
    logic [WIDTH-1:0] a_q, b_q, c_q;
    logic [1:0]       mode_q;

    logic             out_valid_q;
    logic [WIDTH-1:0] d_q, e_q;
    logic [CNT_W-1:0] xfer_cnt_q;

    logic [WIDTH-1:0] f_d, f_e;
    logic             s2_load;
    logic             s1_adv;
    logic             out_xfer;

    // Stage 2 can take new contents when it is empty or being drained this cycle.
    assign s2_load  = ~out_valid_q | out_ready;
    assign s1_adv   = s1_valid_q & s2_load;
    assign in_ready = ~s1_valid_q | s1_adv;
    assign out_xfer = out_valid_q & out_ready;

    gate_eval_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .A    (a_q),
        .B    (b_q),
        .C    (c_q),
        .MODE (mode_q),
        .D    (f_d),
        .E    (f_e)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            mode_q     <= MODE_SOP;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                a_q    <= A;
                b_q    <= B;
                c_q    <= C;
                mode_q <= MODE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_q         <= '0;
            e_q         <= '0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                d_q <= f_d;
                e_q <= f_e;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xfer_cnt_q <= '0;
        end else if (out_xfer) begin
            xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign E         = e_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_gate_eval_pipe.sv
// Randomised and directed bench for gate_eval_pipe checked against a queue-based transaction model.
module tb_gate_eval_pipe;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b, c;
    logic [1:0]   mode;
    logic         in_valid, out_ready;

    logic         in_ready, out_valid;
    logic [W-1:0] d, e;
    logic [15:0]  xfer_cnt;

    logic         w_in_ready, w_out_valid;
    logic [W-1:0] w_d, w_e;
    logic [3:0]   w_cnt;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    gate_eval_pipe #(.WIDTH(W), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .MODE(mode),
        .in_valid(in_valid), .in_ready(in_ready), .D(d), .E(e),
        .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
    );

    gate_eval_pipe #(.WIDTH(W), .CNT_W(4)) dut_wrap (
        .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .MODE(mode),
        .in_valid(in_valid), .in_ready(w_in_ready), .D(w_d), .E(w_e),
        .out_valid(w_out_valid), .out_ready(out_ready), .xfer_cnt(w_cnt)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_d(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                           input logic [W-1:0] rc, input logic [1:0] rm);
        if (rm == 2'd1) return (ra | rb) & ~rc;
        if (rm == 2'd2) return (ra ^ rb) | ~rc;
        return (ra & rb) | ~rc;
    endfunction

    // Transaction model: up to two items in flight; an item becomes visible one edge after entry.
    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] e;
        int           acc;
    } item_t;

    item_t q[$];
    int    edges = 0;
    int    cnt   = 0;

    function automatic bit m_out_valid();
        return q.size() > 0 && q[0].acc < edges - 1;
    endfunction

    function automatic bit m_in_ready();
        return q.size() < 2 || out_ready;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            cnt = 0;
        end else begin
            bit    dep, acc;
            item_t it;
            dep = m_out_valid() && out_ready;
            acc = in_valid && m_in_ready();
            if (dep) begin
                void'(q.pop_front());
                cnt++;
            end
            if (acc) begin
                it.d   = ref_d(a, b, c, mode);
                it.e   = ~c;
                it.acc = edges;
                q.push_back(it);
            end
        end
        edges++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, m_out_valid());
            check("in_ready", in_ready, m_in_ready());
            check("xfer_cnt", xfer_cnt, cnt & 16'hffff);
            check("wrap_out_valid", w_out_valid, m_out_valid());
            check("wrap_cnt", w_cnt, cnt & 15);
            if (m_out_valid()) begin
                check("D", d, q[0].d);
                check("E", e, q[0].e);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] exp_d [4];
        int           sent;
        bit           saw_low;
        int           run, max_run;
        logic [3:0]   last_w;
        logic [3:0]   wlog[$];

        exp_d[0] = 4'b1001;
        exp_d[1] = 4'b1000;
        exp_d[2] = 4'b1111;
        exp_d[3] = 4'b1001;

        rst = 1'b1; a = '0; b = '0; c = '0; mode = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_D", d, 0);
        check("rst_E", e, 0);
        check("rst_cnt", xfer_cnt, 0);

        // Fixed operands through every mode, checking the two-cycle latency.
        for (int m = 0; m < 4; m++) begin
            step();
            a = 4'b1100; b = 4'b1010; c = 4'b0110; mode = 2'(m); in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check("lat1_out_valid", out_valid, 0);
            @(negedge clk);
            check("lat2_out_valid", out_valid, 1);
            check("mode_D", d, exp_d[m]);
            check("mode_E", e, 4'b1001);
        end

        // Backpressure: five distinct vectors, downstream stalled in cycles 3-6.
        sent = 0;
        saw_low = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            step();
            in_valid  = (sent < 5);
            a         = 4'(sent + 1);
            b         = 4'(13 - 2 * sent);
            c         = 4'(3 * sent);
            mode      = 2'(sent % 3);
            out_ready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            if (in_valid && in_ready) sent++;
        end
        check("bp_sent", sent, 5);
        check("bp_in_ready_dropped", saw_low, 1);
        check("bp_cnt", xfer_cnt, 9);

        // Throughput and counter wrap from a clean reset.
        step();
        in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0;
        run = 0; max_run = 0; last_w = 4'd0;
        for (int cyc = 0; cyc < 106; cyc++) begin
            in_valid = (cyc < 100);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
            @(negedge clk);
            if (out_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (w_cnt !== last_w) begin
                wlog.push_back(w_cnt);
                last_w = w_cnt;
            end
            step();
        end
        check("tp_run", max_run, 100);
        check("tp_cnt", xfer_cnt, 100);
        check("wrap_final", w_cnt, 4);
        check("wrap_len_ok", wlog.size() >= 17, 1);
        if (wlog.size() >= 17) begin
            check("wrap_15", wlog[14], 15);
            check("wrap_0", wlog[15], 0);
            check("wrap_1", wlog[16], 1);
        end

        // Random traffic with random backpressure.
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 99) < 65);
            out_ready = ($urandom_range(0, 99) < 60);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
            step();
        end

        // Reset with both stages occupied.
        in_valid = 1'b1; out_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check("full_out_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        step();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_D", d, 0);
        check("mid_rst_E", e, 0);
        check("mid_rst_cnt", xfer_cnt, 0);
        check("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        repeat (4) step();
        @(negedge clk);
        check("post_rst_cnt", xfer_cnt, 0);

        for (int cyc = 0; cyc < 50; cyc++) begin
            step();
            in_valid  = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            c = 4'($urandom_range(0, 15));
            mode = 2'($urandom_range(0, 3));
        end
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
